// File: rtl/i2s_rx_sample_packer.sv
// ----------------------------------------------------------------------------
// i2s_rx_sample_packer
//
// Sits between the I2S RX channel and the uDMA RX path. Incoming 32-bit
// samples are truncated to the configured width (8/16/32 bits) and packed
// lowest lane first into 32-bit words. Finished words go through a small
// output FIFO so that uDMA back-pressure rarely reaches the channel.
//
// Handshakes (both sides): a transfer happens on a rising sck_i edge where
// valid and ready are both high. Valid never depends on ready. in_ready_o is
// derived from registered state and configuration only, so there is no
// combinational path from out_ready_i to in_ready_o.
//
// Ports
//   sck_i            I2S clock, all logic on its rising edge
//   rst_i            synchronous active-high reset
//   cfg_en_i         packer enable; low clears state and drops input
//   cfg_word_size_i  0: 8b (4 lanes), 1: 16b (2 lanes), 2/3: 32b (1 lane)
//   cfg_flush_i      pulse: emit the partial word, unused lanes zero
//   cfg_ovf_clr_i    clears status_ovf_o (wins over a same-cycle set)
//   in_data_i        sample from the RX channel
//   in_valid_i       sample valid
//   in_ready_o       sample accepted when valid & ready
//   out_data_o       packed word at FIFO head (zero when empty)
//   out_valid_o      FIFO not empty
//   out_ready_i      consumer takes the head when valid & ready
//   out_lanes_o      number of valid lanes in the head word (zero when empty)
//   status_ovf_o     sticky: a sample was refused while enabled
// ----------------------------------------------------------------------------
module i2s_rx_sample_packer #(
  parameter int OUT_DEPTH = 4
) (
  input  logic        sck_i,
  input  logic        rst_i,
  input  logic        cfg_en_i,
  input  logic [1:0]  cfg_word_size_i,
  input  logic        cfg_flush_i,
  input  logic        cfg_ovf_clr_i,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [2:0]  out_lanes_o,
  output logic        status_ovf_o
);

  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  // Packing state
  logic [31:0]   acc_q, acc_d;
  logic [1:0]    lane_cnt_q, lane_cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic          ovf_q, ovf_d;

  // Output FIFO state
  logic [31:0]   fifo_data_q  [OUT_DEPTH];
  logic [2:0]    fifo_lanes_q [OUT_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Per-cycle decisions
  logic [1:0]    last_lane;
  logic [2:0]    lanes_per_word;
  logic          fifo_full;
  logic          accept;
  logic          word_done;
  logic          flush_push;
  logic          push;
  logic          pop;
  logic [31:0]   acc_m;
  logic [2:0]    cnt_m;
  logic [2:0]    push_lanes;

  always_comb begin
    case (cfg_word_size_i)
      2'd0:    last_lane = 2'd3;
      2'd1:    last_lane = 2'd1;
      default: last_lane = 2'd0;
    endcase
  end

  assign lanes_per_word = {1'b0, last_lane} + 3'd1;
  assign fifo_full      = (count_q == CW'(OUT_DEPTH));

  // A new lane is refused only when it would need a FIFO slot that does not
  // exist: either it completes the word, or a flush is waiting for a slot
  // and the pending word must not grow.
  assign in_ready_o = cfg_en_i ?
      ~(fifo_full & ((lane_cnt_q == last_lane) | flush_pend_q)) : 1'b1;

  assign accept = cfg_en_i & in_valid_i & in_ready_o;
  assign pop    = cfg_en_i & out_ready_i & (count_q != '0);

  always_comb begin
    acc_m = acc_q;
    if (accept) begin
      case (cfg_word_size_i)
        2'd0:    acc_m[{lane_cnt_q, 3'b000} +: 8]     = in_data_i[7:0];
        2'd1:    acc_m[{lane_cnt_q[0], 4'b0000} +: 16] = in_data_i[15:0];
        default: acc_m = in_data_i;
      endcase
    end
  end

  assign cnt_m     = {1'b0, lane_cnt_q} + {2'b00, accept};
  assign word_done = accept & (lane_cnt_q == last_lane);
  // A word completed this cycle already carries every pending lane, so it
  // takes priority and the pending flush has nothing left to emit.
  assign flush_push = ~word_done & flush_pend_q & ~fifo_full & (cnt_m != 3'd0);
  assign push       = cfg_en_i & (word_done | flush_push);
  assign push_lanes = word_done ? lanes_per_word : cnt_m;

  always_comb begin
    acc_d        = acc_q;
    lane_cnt_d   = lane_cnt_q;
    flush_pend_d = flush_pend_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ovf_d        = ovf_q;

    if (!cfg_en_i) begin
      acc_d        = '0;
      lane_cnt_d   = '0;
      flush_pend_d = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end else begin
      if (push) begin
        acc_d        = '0;
        lane_cnt_d   = '0;
        flush_pend_d = 1'b0;
      end else begin
        acc_d      = acc_m;
        lane_cnt_d = cnt_m[1:0];
      end
      // Flush request is judged against the lane count after this cycle's
      // accept/push; an empty accumulator has nothing to flush.
      if (cfg_flush_i && (lane_cnt_d != 2'd0)) begin
        flush_pend_d = 1'b1;
      end
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      if (in_valid_i && !in_ready_o) begin
        ovf_d = 1'b1;
      end
    end

    if (cfg_ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      acc_q        <= '0;
      lane_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      lane_cnt_q   <= lane_cnt_d;
      flush_pend_q <= flush_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge sck_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q]  <= acc_m;
      fifo_lanes_q[wr_ptr_q] <= push_lanes;
    end
  end

  assign out_valid_o  = (count_q != '0);
  assign out_data_o   = out_valid_o ? fifo_data_q[rd_ptr_q]  : 32'd0;
  assign out_lanes_o  = out_valid_o ? fifo_lanes_q[rd_ptr_q] : 3'd0;
  assign status_ovf_o = ovf_q;

endmodule

// File: tb/tb_i2s_rx_sample_packer.sv
// ----------------------------------------------------------------------------
// tb_i2s_rx_sample_packer
//
// Directed bench for i2s_rx_sample_packer. Inputs change 1 time unit after a
// rising edge; outputs are checked at that same point, well away from the
// next edge. Expected values are written out by hand.
// ----------------------------------------------------------------------------
module tb_i2s_rx_sample_packer;

  // Clock / reset
  logic        sck = 1'b0;
  logic        rst;
  always #5 sck = ~sck;

  logic        cfg_en;
  logic [1:0]  cfg_word_size;
  logic        cfg_flush;
  logic        cfg_ovf_clr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_lanes;
  logic        status_ovf;

  int vec_cnt = 0;
  int err_cnt = 0;

  i2s_rx_sample_packer #(.OUT_DEPTH(4)) dut (
    .sck_i           (sck),
    .rst_i           (rst),
    .cfg_en_i        (cfg_en),
    .cfg_word_size_i (cfg_word_size),
    .cfg_flush_i     (cfg_flush),
    .cfg_ovf_clr_i   (cfg_ovf_clr),
    .in_data_i       (in_data),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .out_data_o      (out_data),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_lanes_o     (out_lanes),
    .status_ovf_o    (status_ovf)
  );

  // Driver tasks
  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One sample, accepted at the next edge; ready must be high beforehand.
  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    check("send_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Word size may only change while disabled.
  task automatic set_ws(input logic [1:0] ws);
    cfg_en = 1'b0;
    tick();
    cfg_word_size = ws;
    cfg_en        = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] d, input logic [2:0] l);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_lanes"}, {29'd0, out_lanes}, {29'd0, l});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    cfg_en        = 1'b1;
    cfg_word_size = 2'd0;
    cfg_flush     = 1'b0;
    cfg_ovf_clr   = 1'b0;
    in_data       = '0;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    tick(); tick(); tick();

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_lanes", {29'd0, out_lanes}, 32'd0);
    check("rst_ovf", {31'd0, status_ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // 8-bit packing, word visible one cycle after the 4th accept
    send(32'h0000AB11);
    send(32'h0000CD22);
    send(32'h0000EF33);
    check("b8_not_yet", {31'd0, out_valid}, 32'd0);
    send(32'h12345644);
    check_head("b8", 32'h44332211, 3'd4);
    tick();
    check("b8_popped", {31'd0, out_valid}, 32'd0);

    // 16-bit packing
    set_ws(2'd1);
    send(32'hAAAA1234);
    send(32'hBBBB5678);
    check_head("b16", 32'h56781234, 3'd2);
    tick();

    // 32-bit passthrough
    set_ws(2'd2);
    send(32'hDEADBEEF);
    check_head("b32", 32'hDEADBEEF, 3'd1);
    tick();
    check("b32_popped", {31'd0, out_valid}, 32'd0);

    // Back-pressure: four words fill the FIFO, fifth sample is refused
    out_ready = 1'b0;
    send(32'h10000001);
    send(32'h20000002);
    send(32'h30000003);
    send(32'h40000004);
    in_valid = 1'b1;
    in_data  = 32'h50000005;
    check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    check("bp_ovf_set", {31'd0, status_ovf}, 32'd1);
    in_valid    = 1'b0;
    cfg_ovf_clr = 1'b1;
    tick();
    cfg_ovf_clr = 1'b0;
    check("bp_ovf_clr", {31'd0, status_ovf}, 32'd0);
    out_ready = 1'b1;
    check_head("bp0", 32'h10000001, 3'd1);
    tick();
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    check_head("bp1", 32'h20000002, 3'd1);
    tick();
    check_head("bp2", 32'h30000003, 3'd1);
    tick();
    check_head("bp3", 32'h40000004, 3'd1);
    tick();
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush of a partial 8-bit word
    set_ws(2'd0);
    send(32'h00000001);
    send(32'h00000002);
    cfg_flush = 1'b1;
    tick();
    cfg_flush = 1'b0;
    check("fl_pending", {31'd0, out_valid}, 32'd0);
    tick();
    check_head("fl", 32'h00000201, 3'd2);
    tick();
    check("fl_popped", {31'd0, out_valid}, 32'd0);
    // Flush with an empty accumulator emits nothing
    cfg_flush = 1'b1;
    tick();
    cfg_flush = 1'b0;
    tick(); tick();
    check("fl_empty_nopush", {31'd0, out_valid}, 32'd0);
    // Accumulator starts clean after a flush
    send(32'h0000000A);
    send(32'h0000000B);
    send(32'h0000000C);
    send(32'h0000000D);
    check_head("fl_next", 32'h0D0C0B0A, 3'd4);
    tick();

    // Flush while the FIFO is full
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(32'(i));
    send(32'h00000055);
    cfg_flush = 1'b1;
    tick();
    cfg_flush = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h00000066;
    check("ff_stall", {31'd0, in_ready}, 32'd0);
    tick();
    check("ff_stall_held", {31'd0, in_ready}, 32'd0);
    check("ff_ovf", {31'd0, status_ovf}, 32'd1);
    in_valid    = 1'b0;
    cfg_ovf_clr = 1'b1;
    check_head("ff_w0", 32'h03020100, 3'd4);
    out_ready = 1'b1;
    tick();
    out_ready   = 1'b0;
    cfg_ovf_clr = 1'b0;
    check_head("ff_w1_wait", 32'h07060504, 3'd4);
    tick();
    out_ready = 1'b1;
    check("ff_ready_back", {31'd0, in_ready}, 32'd1);
    check_head("ff_w1", 32'h07060504, 3'd4);
    tick();
    check_head("ff_w2", 32'h0B0A0908, 3'd4);
    tick();
    check_head("ff_w3", 32'h0F0E0D0C, 3'd4);
    tick();
    check_head("ff_flushed", 32'h00000055, 3'd1);
    tick();
    check("ff_drained", {31'd0, out_valid}, 32'd0);

    // Disable with 2 words stored and 3 lanes buffered
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(32'h30 + 32'(i));
    check_head("dis_before", 32'h33323130, 3'd4);
    in_valid = 1'b1;
    in_data  = 32'h000000FF;
    cfg_en   = 1'b0;
    tick();
    check("dis_out_valid", {31'd0, out_valid}, 32'd0);
    check("dis_no_ovf", {31'd0, status_ovf}, 32'd0);
    check("dis_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    cfg_en   = 1'b1;
    send(32'h00000021);
    send(32'h00000022);
    send(32'h00000023);
    send(32'h00000024);
    check_head("dis_after", 32'h24232221, 3'd4);
    out_ready = 1'b1;
    tick();
    check("dis_drained", {31'd0, out_valid}, 32'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
